// File: rtl/bf_pkg.sv
// Shared definitions for the bf_nb_pipe gate pipeline.
//   MODE_*  : two-bit per-transaction function select
//   bf_eval : golden single-bit result for a given mode; the bench uses it
//             as the reference for every bit of a transaction.
package bf_pkg;

  localparam logic [1:0] MODE_AOI21 = 2'b00;
  localparam logic [1:0] MODE_OAI21 = 2'b01;
  localparam logic [1:0] MODE_AO21  = 2'b10;
  localparam logic [1:0] MODE_OA21  = 2'b11;

  function automatic logic bf_eval(input logic ea, input logic eb,
                                   input logic ec, input logic [1:0] emode);
    logic r;
    case (emode)
      MODE_AOI21: r = ~((ea & eb) | ec);
      MODE_OAI21: r = ~((ea | eb) & ec);
      MODE_AO21:  r = (ea & eb) | ec;
      default:    r = (ea | eb) & ec;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bf_pipe_stage.sv
// One elastic valid/ready register slice.
//   clk, rst_n        : clock, async active-low reset
//   i_valid/i_ready   : upstream handshake (i_ready is combinational from o_ready)
//   i_data            : upstream payload, W bits
//   o_valid/o_ready   : downstream handshake
//   o_data            : registered payload; held while o_valid && !o_ready
module bf_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [W-1:0] o_data
);

  // Slice may advance when empty or when its content leaves this cycle.
  assign i_ready = ~o_valid | o_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (i_ready) begin
      o_valid <= i_valid;
      // Data only moves with a real token so a bubble leaves the last value.
      if (i_valid) o_data <= i_data;
    end
  end

endmodule

// File: rtl/bf_nb_pipe.sv
// Two-stage pipelined AOI21/OAI21/AO21/OA21 gate array with elastic handshake.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : operand handshake (in_ready combinational from out_ready)
//   a, b, c             : WIDTH-bit operands
//   mode                : 00 AOI21, 01 OAI21, 10 AO21, 11 OA21
//   out_valid/out_ready : result handshake
//   out_x, out_zero     : registered result and its zero flag
//   txn_cnt             : completed output handshakes, wrapping
module bf_nb_pipe
  import bf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic             out_zero,
  output logic [CNT_W-1:0] txn_cnt
);

  localparam int S1_W = 2 + 2 * WIDTH;
  localparam int S2_W = 1 + WIDTH;

  logic [WIDTH-1:0] p_comb;
  logic [S1_W-1:0]  s1_d;
  logic [S1_W-1:0]  s1_q;
  logic             s1_valid;
  logic             s2_ready;

  logic [1:0]       s1_mode;
  logic [WIDTH-1:0] s1_c;
  logic [WIDTH-1:0] s1_p;
  logic [WIDTH-1:0] q_comb;
  logic [WIDTH-1:0] x_comb;
  logic [S2_W-1:0]  s2_d;
  logic [S2_W-1:0]  s2_q;

  // mode[0] picks OR-first (OAI/OA) versus AND-first (AOI/AO).
  assign p_comb = mode[0] ? (a | b) : (a & b);
  assign s1_d   = {mode, c, p_comb};

  bf_pipe_stage #(.W(S1_W)) u_s1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (in_valid),
    .i_ready (in_ready),
    .i_data  (s1_d),
    .o_valid (s1_valid),
    .o_ready (s2_ready),
    .o_data  (s1_q)
  );

  assign s1_mode = s1_q[S1_W-1 -: 2];
  assign s1_c    = s1_q[WIDTH +: WIDTH];
  assign s1_p    = s1_q[WIDTH-1:0];

  // mode[1] selects the non-inverted variants.
  assign q_comb = s1_mode[0] ? (s1_p & s1_c) : (s1_p | s1_c);
  assign x_comb = s1_mode[1] ? q_comb : ~q_comb;

  // Zero flag is registered with the result so it reads 0 out of reset.
  assign s2_d = {(x_comb == '0), x_comb};

  bf_pipe_stage #(.W(S2_W)) u_s2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (s1_valid),
    .i_ready (s2_ready),
    .i_data  (s2_d),
    .o_valid (out_valid),
    .o_ready (out_ready),
    .o_data  (s2_q)
  );

  assign out_x    = s2_q[WIDTH-1:0];
  assign out_zero = s2_q[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_cnt <= '0;
    end else if (out_valid && out_ready) begin
      txn_cnt <= txn_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bf_nb_pipe.sv
module tb_bf_nb_pipe;
  import bf_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] c;
  logic [1:0] mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_x;
  logic       out_zero;
  logic [7:0] txn_cnt;

  int checks;
  int errors;
  int cnt_model;
  logic [8:0] sb[$];

  bf_nb_pipe #(.WIDTH(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_zero  (out_zero),
    .txn_cnt   (txn_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each result bit from the golden bit function, zero flag from the whole word.
  function automatic logic [8:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                       input logic [7:0] mc, input logic [1:0] mm);
    logic [7:0] x;
    for (int i = 0; i < 8; i++) x[i] = bf_eval(ma[i], mb[i], mc[i], mm);
    return {(x == 8'h00), x};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic rand_ops();
    a    = 8'($urandom);
    b    = 8'($urandom);
    c    = 8'($urandom);
    mode = 2'($urandom_range(0, 3));
  endtask

  task automatic directed(input logic [7:0] ta, input logic [7:0] tb_v, input logic [7:0] tc,
                          input logic [1:0] tm, input logic [7:0] ex, input logic ez,
                          input string nm);
    a = ta; b = tb_v; c = tc; mode = tm;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({nm, "_lat1_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_x"}, 32'(out_x), 32'(ex));
    chk({nm, "_zero"}, 32'(out_zero), 32'(ez));
    @(posedge clk); #1;
    chk({nm, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int sent;
    int cyc;
    int acc;
    logic tk;
    logic have;
    logic [7:0] held;

    checks = 0; errors = 0; cnt_model = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c = '0; mode = '0;

    // Scoreboard monitor: expected results queued on input transfer, popped on output transfer.
    fork
      forever begin
        @(negedge clk or negedge rst_n);
        if (!rst_n) begin
          sb.delete();
          cnt_model = 0;
        end else begin
          chk("txn_cnt_track", 32'(txn_cnt), 32'(cnt_model % 256));
          if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_output: got %0h expected none", out_x);
            end else begin
              logic [8:0] e;
              e = sb.pop_front();
              chk("sb_x", 32'(out_x), 32'(e[7:0]));
              chk("sb_zero", 32'(out_zero), 32'(e[8]));
            end
            cnt_model++;
          end
          if (in_valid && in_ready) sb.push_back(model(a, b, c, mode));
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_x", 32'(out_x), 32'd0);
    chk("rst_out_zero", 32'(out_zero), 32'd0);
    chk("rst_txn_cnt", 32'(txn_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed modes on the same operands
    directed(8'hF0, 8'hCC, 8'h01, MODE_AOI21, 8'h3E, 1'b0, "aoi21");
    directed(8'hF0, 8'hCC, 8'h01, MODE_OAI21, 8'hFF, 1'b0, "oai21");
    directed(8'hF0, 8'hCC, 8'h01, MODE_AO21,  8'hC1, 1'b0, "ao21");
    directed(8'hF0, 8'hCC, 8'h01, MODE_OA21,  8'h00, 1'b1, "oa21");
    chk("directed_cnt", 32'(txn_cnt), 32'd4);

    // Back-to-back: results on four consecutive cycles
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k < 4) begin
        in_valid = 1'b1;
        rand_ops();
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk("b2b_out_valid", 32'(out_valid), 32'((k >= 1) && (k <= 4)));
    end
    chk("b2b_cnt", 32'(txn_cnt), 32'd8);

    // Stall: consumer blocked, producer always valid
    out_ready = 1'b0; in_valid = 1'b1; rand_ops();
    acc = 0; have = 1'b0; held = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tk = in_valid && in_ready;
      if (tk) acc++;
      if (out_valid) begin
        if (!have) begin
          held = out_x;
          have = 1'b1;
        end else begin
          chk("stall_hold_x", 32'(out_x), 32'(held));
        end
      end
      @(posedge clk); #1;
      if (tk) rand_ops();
    end
    chk("stall_accepts", 32'(acc), 32'd2);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while ((out_valid || sb.size() != 0) && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 20) begin
      checks++; errors++;
      $display("FAIL stall_drain_timeout: got %0d cycles expected < 20", cyc);
    end
    chk("stall_cnt", 32'(txn_cnt), 32'd10);

    // Reset mid-stream with both stages full
    out_ready = 1'b0; in_valid = 1'b1; rand_ops();
    @(posedge clk); #1; rand_ops();
    @(posedge clk); #1;
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_x", 32'(out_x), 32'd0);
    chk("midrst_txn_cnt", 32'(txn_cnt), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("midrst_no_output", 32'(out_valid), 32'd0);
    end

    // Random traffic: 300 transfers, counter wraps
    sent = 0; cyc = 0; in_valid = 1'b0;
    while ((sent < 300 || sb.size() != 0 || out_valid) && cyc < 5000) begin
      if (!in_valid && sent < 300 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        rand_ops();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      tk = in_valid && in_ready;
      if (tk) sent++;
      @(posedge clk); #1;
      if (tk) in_valid = 1'b0;
      cyc++;
    end
    if (cyc >= 5000) begin
      checks++; errors++;
      $display("FAIL random_timeout: got %0d sent expected 300", sent);
    end
    chk("random_sent", 32'(sent), 32'd300);
    chk("random_model_cnt", 32'(cnt_model), 32'd300);
    chk("random_txn_cnt", 32'(txn_cnt), 32'd44);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
